axi_burst_write_ctrl: RTL and testbench
=======================================

// Module: axi_burst_write_ctrl
// PURPOSE: AXI4 write-channel-to-SRAM controller for the dual-port AXI memory wrapper. Supports FIXED/INCR/WRAP bursts,
//   narrow transfers (AWSIZE) and SLVERR reporting, and overlaps the B response with acceptance of the next AW.
// PARAMETERS
//   AXI4_ADDRESS_WIDTH  32   AW byte-address width
//   AXI4_WDATA_WIDTH    64   W data width; power of two, >=8
//   AXI4_ID_WIDTH       16   AWID/BID width
//   AXI_NUMBYTES        AXI4_WDATA_WIDTH/8   strobe width (derived)
//   MEM_ADDR_WIDTH      13   SRAM word-address width
// PORTS
//   clk        in   1    clock
//   rst        in   1    asynchronous reset, active-high
//   AWID_i     in   ID   write ID
//   AWADDR_i   in   AW   start byte address
//   AWLEN_i    in   8    beats-1
//   AWSIZE_i   in   3    log2 bytes per beat
//   AWBURST_i  in   2    00 FIXED, 01 INCR, 10 WRAP
//   AWVALID_i  in   1    AW valid
//   AWREADY_o  out  1    AW ready
//   WDATA_i    in   DW   write data
//   WSTRB_i    in   NB   byte strobes
//   WLAST_i    in   1    last beat flag
//   WVALID_i   in   1    W valid
//   WREADY_o   out  1    W ready
//   BID_o      out  ID   response ID
//   BRESP_o    out  2    OKAY/SLVERR
//   BVALID_o   out  1    B valid
//   BREADY_i   in   1    B ready
//   MEM_CEN_o  out  1    SRAM chip enable, active-low
//   MEM_WEN_o  out  1    SRAM write enable, active-low (0 whenever CEN=0)
//   MEM_A_o    out  MA   SRAM word address
//   MEM_D_o    out  DW   SRAM write data (=WDATA_i)
//   MEM_BE_o   out  NB   SRAM byte enables (=WSTRB_i)
//   grant_i    in   1    port arbiter grant
//   valid_o    out  1    port request to arbiter
// BEHAVIOUR
//   Reset (rst=1, async): state IDLE, AWREADY_o/WREADY_o/BVALID_o/valid_o=0, MEM_CEN_o=1, BRESP_o=OKAY, BID_o=0, counters 0.
//     A burst in flight at reset is dropped: no B response is issued for it.
//   FSM IDLE->DATA->RESP:
//     IDLE: AWREADY_o=1. The AW handshake registers ID, byte address, LEN, SIZE, BURST and err -> DATA.
//     W is never accepted in the AW cycle; AW-to-first-W latency is 1 cycle.
//   AW err (SLVERR) when any of:
//     AWSIZE > log2(NB); AWBURST=11; WRAP with LEN not in {1,3,7,15}.
//   DATA, no err:
//     valid_o=WVALID_i; WREADY_o=grant_i; beat handshake = WVALID_i & grant_i.
//     MEM_CEN_o = ~handshake; MEM_A_o = addr_q[MA+log2(NB)-1:log2(NB)]. The write is issued in the handshake cycle.
//   DATA, err: WREADY_o=1, valid_o=0, MEM_CEN_o=1; all beats are drained with no writes.
//   Beat counter (8b) increments per handshake. At cnt==LEN -> RESP.
//     WLAST_i != (cnt==LEN) on any beat sets a sticky SLVERR. Beat count, not WLAST, ends the burst.
//   Address step per beat:
//     FIXED: hold. INCR: addr += 1<<SIZE (full-width add, no 4KB check).
//     WRAP: mask = ((LEN+1)<<SIZE)-1; addr = (addr & ~mask) | ((addr + (1<<SIZE)) & mask).
//   RESP: BVALID_o=1; BID_o/BRESP_o held stable until BREADY_i.
//     AWREADY_o=BREADY_i, so a B handshake and a new AW handshake in the same cycle -> DATA directly (no idle cycle).
//     B handshake without AWVALID_i -> IDLE.
// CONFIGURATION
//   AXI_WCTRL_WRAP_EN defined: WRAP bursts are supported as above.
//   AXI_WCTRL_WRAP_EN undefined: AWBURST=10 is an AW err (drained, SLVERR) and no mask logic is built.
// STRUCTURE
//   Package axi_wctrl_pkg: state enum; BURST_FIXED/INCR/WRAP; RESP_OKAY/EXOKAY/SLVERR/DECERR.
//   Sub-module axi_wctrl_addr_gen: combinational next-address from (addr, size, len, burst); holds the WRAP macro guard.
// TESTING
//   INCR LEN=0 SIZE=3 AWADDR=0x100 WDATA=0xDEAD WSTRB=0xFF -> one write MEM_A=0x20 BE=0xFF; BRESP=OKAY, BID=AWID.
//   INCR LEN=3 SIZE=3 AWADDR=0x40, grant_i low 2 cycles at beat 1 -> MEM_A 8,9,10,11; WREADY_o low while ungranted.
//   Narrow SIZE=2 LEN=3 AWADDR=0x4 -> MEM_A 0,1,1,2 (bytes 4,8,C,10); BRESP=OKAY.
//   WRAP LEN=3 SIZE=3 AWADDR=0x18 -> MEM_A 3,0,1,2 (macro on); macro off -> 4 beats drained, no CEN, BRESP=SLVERR.
//   LEN=2 with WLAST on beat 1 -> 3 writes, BRESP=SLVERR; SIZE=4 on 64b bus -> no writes, SLVERR.
//   Second AWVALID held during RESP with BREADY=1 -> AW accepted in the B cycle, DATA next; rst mid-burst -> IDLE, BVALID=0.

Source files
------------

// File: rtl/axi_wctrl_pkg.sv
// Shared types for the AXI4 write-channel-to-SRAM controller.
//   wctrl_state_e : controller FSM states
//   axi_burst_e   : AWBURST encodings
//   axi_resp_e    : BRESP encodings
//   wrap_len_ok() : legal WRAP burst lengths (2, 4, 8 or 16 beats)
package axi_wctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wctrl_state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_wctrl_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts (purely combinational).
// Macro AXI_WCTRL_WRAP_EN: when undefined no wrap-mask logic is built and WRAP
// falls back to holding the address (such bursts are rejected upstream anyway).
//   addr      : current beat byte address
//   size      : log2 bytes per beat
//   len       : beats-1
//   burst     : AWBURST encoding
//   next_addr : byte address of the following beat
module axi_wctrl_addr_gen
  import axi_wctrl_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;
  assign step = AW'(1) << size;

`ifdef AXI_WCTRL_WRAP_EN
  // Wrap window spans the whole burst: (LEN+1) beats of 2^SIZE bytes.
  logic [AW-1:0] mask;
  assign mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
`else
  logic [7:0] unused_len;
  assign unused_len = len;
`endif

  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = addr + step;
`ifdef AXI_WCTRL_WRAP_EN
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + step) & mask);
`endif
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_write_ctrl.sv
// AXI4 write channel to single-port SRAM controller (FIXED/INCR/WRAP, narrow
// transfers, SLVERR). The B response overlaps acceptance of the next AW.
// Macro AXI_WCTRL_WRAP_EN enables WRAP bursts; otherwise WRAP is an AW error.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   AW*                      : write address channel (AWREADY_o out)
//   W*                       : write data channel (WREADY_o out)
//   B*                       : write response channel (BREADY_i in)
//   MEM_CEN_o/WEN_o/A_o/D_o/BE_o : SRAM write port, issued in the W handshake cycle
//   grant_i / valid_o        : SRAM port arbitration
module axi_burst_write_ctrl
  import axi_wctrl_pkg::*;
#(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_WDATA_WIDTH   = 64,
  parameter int unsigned AXI4_ID_WIDTH      = 16,
  parameter int unsigned AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
  parameter int unsigned MEM_ADDR_WIDTH     = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
  input  logic [7:0]                    AWLEN_i,
  input  logic [2:0]                    AWSIZE_i,
  input  logic [1:0]                    AWBURST_i,
  input  logic                          AWVALID_i,
  output logic                          AWREADY_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
  input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
  input  logic                          WLAST_i,
  input  logic                          WVALID_i,
  output logic                          WREADY_o,
  output logic [AXI4_ID_WIDTH-1:0]      BID_o,
  output logic [1:0]                    BRESP_o,
  output logic                          BVALID_o,
  input  logic                          BREADY_i,
  output logic                          MEM_CEN_o,
  output logic                          MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
  output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
  input  logic                          grant_i,
  output logic                          valid_o
);

  localparam int unsigned NB_LOG = $clog2(AXI_NUMBYTES);

  wctrl_state_e                  state_q;
  logic [AXI4_ID_WIDTH-1:0]      id_q;
  logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
  logic [AXI4_ADDRESS_WIDTH-1:0] next_addr;
  logic [7:0]                    len_q;
  logic [2:0]                    size_q;
  logic [1:0]                    burst_q;
  logic                          aw_err_q;
  logic                          last_err_q;
  logic [7:0]                    cnt_q;
  logic [AXI4_ID_WIDTH-1:0]      bid_q;
  logic [1:0]                    bresp_q;

  logic aw_err;
  logic aw_hs;
  logic w_hs;
  logic mem_hs;
  logic beat_last;
  logic last_mismatch;

  // AW legality check, evaluated on the incoming request.
  always_comb begin
    aw_err = 1'b0;
    if (AWSIZE_i > 3'(NB_LOG)) aw_err = 1'b1;
    if (AWBURST_i == BURST_RSVD) aw_err = 1'b1;
`ifdef AXI_WCTRL_WRAP_EN
    if ((AWBURST_i == BURST_WRAP) && !wrap_len_ok(AWLEN_i)) aw_err = 1'b1;
`else
    if (AWBURST_i == BURST_WRAP) aw_err = 1'b1;
`endif
  end

  // AW is taken in IDLE, or in RESP together with the B handshake.
  assign AWREADY_o = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & BREADY_i));
  // Errored bursts drain W without arbitrating for the SRAM.
  assign WREADY_o  = (state_q == ST_DATA) & (aw_err_q | grant_i);
  assign valid_o   = (state_q == ST_DATA) & ~aw_err_q & WVALID_i;
  assign BVALID_o  = (state_q == ST_RESP);
  assign BID_o     = bid_q;
  assign BRESP_o   = bresp_q;

  assign aw_hs         = AWVALID_i & AWREADY_o;
  assign w_hs          = WVALID_i & WREADY_o;
  assign mem_hs        = w_hs & ~aw_err_q;
  assign beat_last     = (cnt_q == len_q);
  assign last_mismatch = (WLAST_i != beat_last);

  assign MEM_CEN_o = ~mem_hs;
  assign MEM_WEN_o = ~mem_hs;
  assign MEM_A_o   = addr_q[MEM_ADDR_WIDTH+NB_LOG-1:NB_LOG];
  assign MEM_D_o   = WDATA_i;
  assign MEM_BE_o  = WSTRB_i;

  axi_wctrl_addr_gen #(
    .AW(AXI4_ADDRESS_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // FSM and burst context; a burst in flight at reset is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      aw_err_q   <= 1'b0;
      last_err_q <= 1'b0;
      cnt_q      <= '0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        id_q       <= AWID_i;
        addr_q     <= AWADDR_i;
        len_q      <= AWLEN_i;
        size_q     <= AWSIZE_i;
        burst_q    <= AWBURST_i;
        aw_err_q   <= aw_err;
        last_err_q <= 1'b0;
        cnt_q      <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (aw_hs) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (w_hs) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr;
            if (last_mismatch) last_err_q <= 1'b1;
            // Beat count, not WLAST, terminates the burst.
            if (beat_last) begin
              state_q <= ST_RESP;
              bid_q   <= id_q;
              bresp_q <= (aw_err_q | last_err_q | last_mismatch) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        ST_RESP: begin
          if (BREADY_i) state_q <= aw_hs ? ST_DATA : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_write_ctrl.sv
// Directed testbench for axi_burst_write_ctrl: inputs change 1ns after the
// rising edge, outputs are sampled on the falling edge.
module tb_axi_burst_write_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] AWID_i;
  logic [31:0] AWADDR_i;
  logic [7:0]  AWLEN_i;
  logic [2:0]  AWSIZE_i;
  logic [1:0]  AWBURST_i;
  logic        AWVALID_i;
  logic        AWREADY_o;
  logic [63:0] WDATA_i;
  logic [7:0]  WSTRB_i;
  logic        WLAST_i;
  logic        WVALID_i;
  logic        WREADY_o;
  logic [15:0] BID_o;
  logic [1:0]  BRESP_o;
  logic        BVALID_o;
  logic        BREADY_i;
  logic        MEM_CEN_o;
  logic        MEM_WEN_o;
  logic [12:0] MEM_A_o;
  logic [63:0] MEM_D_o;
  logic [7:0]  MEM_BE_o;
  logic        grant_i;
  logic        valid_o;

  axi_burst_write_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .AWID_i    (AWID_i),
    .AWADDR_i  (AWADDR_i),
    .AWLEN_i   (AWLEN_i),
    .AWSIZE_i  (AWSIZE_i),
    .AWBURST_i (AWBURST_i),
    .AWVALID_i (AWVALID_i),
    .AWREADY_o (AWREADY_o),
    .WDATA_i   (WDATA_i),
    .WSTRB_i   (WSTRB_i),
    .WLAST_i   (WLAST_i),
    .WVALID_i  (WVALID_i),
    .WREADY_o  (WREADY_o),
    .BID_o     (BID_o),
    .BRESP_o   (BRESP_o),
    .BVALID_o  (BVALID_o),
    .BREADY_i  (BREADY_i),
    .MEM_CEN_o (MEM_CEN_o),
    .MEM_WEN_o (MEM_WEN_o),
    .MEM_A_o   (MEM_A_o),
    .MEM_D_o   (MEM_D_o),
    .MEM_BE_o  (MEM_BE_o),
    .grant_i   (grant_i),
    .valid_o   (valid_o)
  );

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  int n_checks = 0;
  int n_pass   = 0;
  int n_beats  = 0;

  logic [12:0] wr_a[$];
  logic [63:0] wr_d[$];
  logic [7:0]  wr_be[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every SRAM write and every W beat accepted.
  always @(negedge clk) begin
    if (!rst && !MEM_CEN_o) begin
      wr_a.push_back(MEM_A_o);
      wr_d.push_back(MEM_D_o);
      wr_be.push_back(MEM_BE_o);
    end
    if (!rst && WVALID_i && WREADY_o) n_beats++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    wr_be.delete();
    n_beats = 0;
  endtask

  task automatic send_aw(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    AWID_i = id; AWADDR_i = addr; AWLEN_i = len; AWSIZE_i = size; AWBURST_i = burst;
    AWVALID_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!AWREADY_o && t < 50) begin @(negedge clk); t++; end
    if (!AWREADY_o) check("aw_timeout", 64'(AWREADY_o), 64'd1);
    @(posedge clk); #1;
    AWVALID_i = 1'b0;
    clear_log();
  endtask

  // n beats, WLAST raised on beat last_idx (pass n-1 for a well-formed burst).
  task automatic send_w(input int n, input int last_idx, input logic [63:0] base);
    int t;
    for (int i = 0; i < n; i++) begin
      WVALID_i = 1'b1;
      WDATA_i  = base + 64'(i);
      WSTRB_i  = 8'hFF;
      WLAST_i  = (i == last_idx);
      t = 0;
      @(negedge clk);
      while (!WREADY_o && t < 50) begin @(negedge clk); t++; end
      if (!WREADY_o) check("w_timeout", 64'(WREADY_o), 64'd1);
      @(posedge clk); #1;
    end
    WVALID_i = 1'b0;
    WLAST_i  = 1'b0;
  endtask

  task automatic expect_writes(input string tag, input int n, input logic [12:0] a0,
                               input logic [12:0] a1, input logic [12:0] a2, input logic [12:0] a3);
    logic [12:0] e[4];
    e = '{a0, a1, a2, a3};
    check({tag, "_nwr"}, 64'(wr_a.size()), 64'(n));
    for (int i = 0; i < n && i < wr_a.size(); i++) check({tag, "_addr"}, 64'(wr_a[i]), 64'(e[i]));
  endtask

  task automatic wait_b(input string tag, input logic [15:0] id, input logic [1:0] resp);
    int t;
    t = 0;
    @(negedge clk);
    while (!BVALID_o && t < 50) begin @(negedge clk); t++; end
    check({tag, "_bvalid"}, 64'(BVALID_o), 64'd1);
    check({tag, "_bid"}, 64'(BID_o), 64'(id));
    check({tag, "_bresp"}, 64'(BRESP_o), 64'(resp));
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_bresp_hold"}, 64'(BRESP_o), 64'(resp));
    @(posedge clk); #1;
    BREADY_i = 1'b1;
    @(posedge clk); #1;
    BREADY_i = 1'b0;
    @(negedge clk);
    check({tag, "_bdone"}, 64'(BVALID_o), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    AWID_i = '0; AWADDR_i = '0; AWLEN_i = '0; AWSIZE_i = '0; AWBURST_i = '0; AWVALID_i = 1'b0;
    WDATA_i = '0; WSTRB_i = '0; WLAST_i = 1'b0; WVALID_i = 1'b0;
    BREADY_i = 1'b0; grant_i = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_awready", 64'(AWREADY_o), 64'd0);
    check("rst_wready",  64'(WREADY_o),  64'd0);
    check("rst_bvalid",  64'(BVALID_o),  64'd0);
    check("rst_valid",   64'(valid_o),   64'd0);
    check("rst_cen",     64'(MEM_CEN_o), 64'd1);
    check("rst_bresp",   64'(BRESP_o),   64'(OKAY));
    check("rst_bid",     64'(BID_o),     64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", 64'(AWREADY_o), 64'd1);
    @(posedge clk); #1;

    // Single INCR beat; W is not ready in the AW cycle
    AWID_i = 16'h1234; AWADDR_i = 32'h100; AWLEN_i = 8'd0; AWSIZE_i = 3'd3; AWBURST_i = 2'b01;
    AWVALID_i = 1'b1; WVALID_i = 1'b1; WDATA_i = 64'hDEAD; WSTRB_i = 8'hFF; WLAST_i = 1'b1;
    @(negedge clk);
    check("aw_cycle_wready", 64'(WREADY_o), 64'd0);
    check("aw_cycle_cen", 64'(MEM_CEN_o), 64'd1);
    WVALID_i = 1'b0; WLAST_i = 1'b0;
    @(posedge clk); #1;
    AWVALID_i = 1'b0;
    clear_log();
    send_w(1, 0, 64'hDEAD);
    expect_writes("single", 1, 13'h20, 13'h0, 13'h0, 13'h0);
    if (wr_d.size() > 0) begin
      check("single_data", wr_d[0], 64'hDEAD);
      check("single_be", 64'(wr_be[0]), 64'hFF);
    end
    wait_b("single", 16'h1234, OKAY);

    // INCR 4 beats with grant withheld for 2 cycles at beat 1
    send_aw(16'h0002, 32'h40, 8'd3, 3'd3, 2'b01);
    WVALID_i = 1'b1; WSTRB_i = 8'hFF; WDATA_i = 64'd0; WLAST_i = 1'b0;
    @(posedge clk); #1;
    WDATA_i = 64'd1; grant_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_wready", 64'(WREADY_o), 64'd0);
      check("stall_valid", 64'(valid_o), 64'd1);
      check("stall_cen", 64'(MEM_CEN_o), 64'd1);
      @(posedge clk); #1;
    end
    grant_i = 1'b1;
    @(posedge clk); #1;
    WDATA_i = 64'd2;
    @(posedge clk); #1;
    WDATA_i = 64'd3; WLAST_i = 1'b1;
    @(posedge clk); #1;
    WVALID_i = 1'b0; WLAST_i = 1'b0;
    expect_writes("stall", 4, 13'd8, 13'd9, 13'd10, 13'd11);
    wait_b("stall", 16'h0002, OKAY);

    // Narrow 32-bit beats
    send_aw(16'h0003, 32'h4, 8'd3, 3'd2, 2'b01);
    send_w(4, 3, 64'h10);
    expect_writes("narrow", 4, 13'd0, 13'd1, 13'd1, 13'd2);
    wait_b("narrow", 16'h0003, OKAY);

    // WRAP 4x8 bytes from 0x18
    send_aw(16'h0004, 32'h18, 8'd3, 3'd3, 2'b10);
    send_w(4, 3, 64'h20);
`ifdef AXI_WCTRL_WRAP_EN
    expect_writes("wrap", 4, 13'd3, 13'd0, 13'd1, 13'd2);
    wait_b("wrap", 16'h0004, OKAY);
`else
    check("wrap_off_beats", 64'(n_beats), 64'd4);
    expect_writes("wrap_off", 0, 13'd0, 13'd0, 13'd0, 13'd0);
    wait_b("wrap_off", 16'h0004, SLVERR);
`endif

    // Early WLAST: all 3 beats still written, SLVERR
    send_aw(16'h0005, 32'h0, 8'd2, 3'd3, 2'b01);
    send_w(3, 1, 64'h30);
    expect_writes("early_last", 3, 13'd0, 13'd1, 13'd2, 13'd0);
    wait_b("early_last", 16'h0005, SLVERR);

    // SIZE=4 on a 64-bit bus: drained without writes, even with grant low
    send_aw(16'h0006, 32'h0, 8'd1, 3'd4, 2'b01);
    grant_i = 1'b0;
    send_w(2, 1, 64'h40);
    grant_i = 1'b1;
    check("oversize_beats", 64'(n_beats), 64'd2);
    expect_writes("oversize", 0, 13'd0, 13'd0, 13'd0, 13'd0);
    wait_b("oversize", 16'h0006, SLVERR);

    // Reserved burst type
    send_aw(16'h0007, 32'h0, 8'd0, 3'd3, 2'b11);
    send_w(1, 0, 64'h50);
    expect_writes("rsvd", 0, 13'd0, 13'd0, 13'd0, 13'd0);
    wait_b("rsvd", 16'h0007, SLVERR);

    // B handshake overlapped with next AW
    send_aw(16'h000A, 32'h80, 8'd0, 3'd3, 2'b01);
    send_w(1, 0, 64'h60);
    AWID_i = 16'h0055; AWADDR_i = 32'h200; AWLEN_i = 8'd0; AWSIZE_i = 3'd3; AWBURST_i = 2'b01;
    AWVALID_i = 1'b1; BREADY_i = 1'b1;
    @(negedge clk);
    check("ovl_bvalid", 64'(BVALID_o), 64'd1);
    check("ovl_awready", 64'(AWREADY_o), 64'd1);
    check("ovl_bid", 64'(BID_o), 64'h000A);
    @(posedge clk); #1;
    AWVALID_i = 1'b0; BREADY_i = 1'b0;
    clear_log();
    @(negedge clk);
    check("ovl_data_bvalid", 64'(BVALID_o), 64'd0);
    check("ovl_data_wready", 64'(WREADY_o), 64'd1);
    check("ovl_data_awready", 64'(AWREADY_o), 64'd0);
    @(posedge clk); #1;
    send_w(1, 0, 64'h70);
    expect_writes("ovl", 1, 13'h40, 13'd0, 13'd0, 13'd0);
    wait_b("ovl", 16'h0055, OKAY);

    // Reset mid-burst drops it
    send_aw(16'h0077, 32'h0, 8'd3, 3'd3, 2'b01);
    send_w(1, 3, 64'h80);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bvalid", 64'(BVALID_o), 64'd0);
    check("midrst_wready", 64'(WREADY_o), 64'd0);
    check("midrst_awready", 64'(AWREADY_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_bvalid", 64'(BVALID_o), 64'd0);
    check("postrst_awready", 64'(AWREADY_o), 64'd1);
    @(posedge clk); #1;
    send_aw(16'h0078, 32'h8, 8'd0, 3'd3, 2'b00);
    send_w(1, 0, 64'h90);
    expect_writes("postrst", 1, 13'd1, 13'd0, 13'd0, 13'd0);
    wait_b("postrst", 16'h0078, OKAY);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
